fc_stream_acc: RTL and testbench

- Time-multiplexed fully connected layer for the BWN classifier head.
- Streams one activation per handshake, together with that activation's weight row for all CLASS_NUM channels, and keeps one accumulator per channel.
- After INPUT_SIZE activations it adds the biases, saturates, optionally applies ReLU and computes the argmax class. Adds multi-bit weights, backpressure, saturation and argmax.
- Result is held until the downstream consumer accepts it, then the next frame starts.

---
 rtl/fc_stream_acc.sv | 161 ++++++++++++++++
 tb/tb_fc_stream_acc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_stream_acc.sv
// fc_stream_acc: time-multiplexed fully connected layer for the classifier head.
// Accepts one activation per handshake with its weight row for all channels and
// keeps one accumulator per channel. After INPUT_SIZE activations it adds the
// biases, saturates, optionally applies ReLU and computes the argmax class. The
// result is held until the consumer accepts it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready activation beat handshake (x, f_w)
//   x                 signed activation, Q(D_WL-FL).FL
//   f_w               weights, channel j at [j*W_WL +: W_WL]
//   f_b               biases, channel j at [j*D_WL +: D_WL], held for the frame
//   o_valid/o_ready   result handshake
//   f_o               results, channel j at [j*D_WL +: D_WL]
//   o_class           index of the largest f_o channel (lowest index on ties)
module fc_stream_acc #(
    parameter int unsigned CLASS_NUM  = 30,
    parameter int unsigned INPUT_SIZE = 162,
    parameter int unsigned D_WL       = 16,
    parameter int unsigned FL         = 8,
    parameter int unsigned W_WL       = 1,
    parameter int unsigned WFL        = 0,
    parameter int unsigned RELU_EN    = 0
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  in_valid,
    output logic                                                  in_ready,
    input  logic [D_WL-1:0]                                       x,
    input  logic [CLASS_NUM*W_WL-1:0]                             f_w,
    input  logic [CLASS_NUM*D_WL-1:0]                             f_b,
    output logic                                                  o_valid,
    input  logic                                                  o_ready,
    output logic [CLASS_NUM*D_WL-1:0]                             f_o,
    output logic [((CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1)-1:0]  o_class
);

    localparam int unsigned ACC_WL  = D_WL + W_WL + $clog2(INPUT_SIZE) + 1;
    localparam int unsigned SUM_WL  = ACC_WL + 1;
    localparam int unsigned PROD_WL = D_WL + W_WL;
    // The product carries FL+WFL fractional bits; shift back to FL.
    localparam int unsigned PROD_FL = FL + WFL;
    localparam int unsigned CNT_WL  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
    localparam int unsigned CLS_WL  = (CLASS_NUM > 1) ? $clog2(CLASS_NUM) : 1;

    localparam logic signed [D_WL-1:0] D_MAX = {1'b0, {(D_WL-1){1'b1}}};
    localparam logic signed [D_WL-1:0] D_MIN = {1'b1, {(D_WL-1){1'b0}}};

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        BIAS = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                     state, state_nxt;
    logic [CNT_WL-1:0]          cnt;
    logic signed [ACC_WL-1:0]   acc  [CLASS_NUM];
    logic signed [ACC_WL-1:0]   term [CLASS_NUM];
    logic signed [W_WL-1:0]     w_s  [CLASS_NUM];
    logic signed [PROD_WL-1:0]  prod [CLASS_NUM];
    logic signed [SUM_WL-1:0]   sum  [CLASS_NUM];
    logic signed [D_WL-1:0]     sat  [CLASS_NUM];
    logic signed [D_WL-1:0]     best_val;
    logic [CLS_WL-1:0]          best_idx;
    logic                       beat;
    logic                       last;

    assign in_ready = (state == ACC);
    assign o_valid  = (state == OUT);
    assign beat     = in_valid && in_ready;
    assign last     = (cnt == CNT_WL'(INPUT_SIZE - 1));

    // Per-channel contribution of the current activation.
    always_comb begin
        for (int j = 0; j < CLASS_NUM; j++) begin
            w_s[j]  = $signed(f_w[j*W_WL +: W_WL]);
            prod[j] = PROD_WL'($signed(x)) * PROD_WL'(w_s[j]);
            if (W_WL == 1) begin
                // Binary weight: 1 adds x, 0 subtracts x.
                term[j] = f_w[j*W_WL] ? ACC_WL'($signed(x)) : -ACC_WL'($signed(x));
            end else begin
                term[j] = ACC_WL'(prod[j] >>> (PROD_FL - FL));
            end
        end
    end

    // Bias add, saturation to the output word and optional ReLU.
    always_comb begin
        for (int j = 0; j < CLASS_NUM; j++) begin
            sum[j] = SUM_WL'(acc[j]) + SUM_WL'($signed(f_b[j*D_WL +: D_WL]));
            if (sum[j] > SUM_WL'(D_MAX)) begin
                sat[j] = D_MAX;
            end else if (sum[j] < SUM_WL'(D_MIN)) begin
                sat[j] = D_MIN;
            end else begin
                sat[j] = $signed(sum[j][D_WL-1:0]);
            end
            if ((RELU_EN != 0) && sat[j][D_WL-1]) begin
                sat[j] = '0;
            end
        end
    end

    // Argmax over the final channel values; strict compare keeps the lowest index on ties.
    always_comb begin
        best_val = sat[0];
        best_idx = '0;
        for (int j = 1; j < CLASS_NUM; j++) begin
            if (sat[j] > best_val) begin
                best_val = sat[j];
                best_idx = CLS_WL'(j);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ACC:     if (beat && last) state_nxt = BIAS;
            BIAS:    state_nxt = OUT;
            OUT:     if (o_ready) state_nxt = ACC;
            default: state_nxt = ACC;
        endcase
    end

    // Accumulators, element counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            f_o     <= '0;
            o_class <= '0;
            for (int j = 0; j < CLASS_NUM; j++) begin
                acc[j] <= '0;
            end
        end else begin
            if (state == ACC && beat) begin
                cnt <= last ? '0 : cnt + CNT_WL'(1);
                for (int j = 0; j < CLASS_NUM; j++) begin
                    acc[j] <= acc[j] + term[j];
                end
            end
            if (state == BIAS) begin
                o_class <= best_idx;
                for (int j = 0; j < CLASS_NUM; j++) begin
                    f_o[j*D_WL +: D_WL] <= sat[j];
                    acc[j]              <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_stream_acc.sv
// tb_fc_stream_acc: directed, table-driven bench for fc_stream_acc with three
// instances sharing the stimulus: binary weights, binary weights with ReLU, and
// 4-bit weights (WFL=2).
module tb_fc_stream_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] x;
    logic [2:0]  f_w;
    logic [11:0] f_w4;
    logic [47:0] f_b;
    logic        o_ready;

    logic        in_ready_a, in_ready_r, in_ready_m;
    logic        o_valid_a, o_valid_r, o_valid_m;
    logic [47:0] f_o_a, f_o_r, f_o_m;
    logic [1:0]  o_class_a, o_class_r, o_class_m;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fc_stream_acc #(.CLASS_NUM(3), .INPUT_SIZE(4), .D_WL(16), .FL(8),
                    .W_WL(1), .WFL(0), .RELU_EN(0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .x(x), .f_w(f_w), .f_b(f_b), .o_valid(o_valid_a), .o_ready(o_ready),
        .f_o(f_o_a), .o_class(o_class_a));

    fc_stream_acc #(.CLASS_NUM(3), .INPUT_SIZE(4), .D_WL(16), .FL(8),
                    .W_WL(1), .WFL(0), .RELU_EN(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .x(x), .f_w(f_w), .f_b(f_b), .o_valid(o_valid_r), .o_ready(o_ready),
        .f_o(f_o_r), .o_class(o_class_r));

    fc_stream_acc #(.CLASS_NUM(3), .INPUT_SIZE(4), .D_WL(16), .FL(8),
                    .W_WL(4), .WFL(2), .RELU_EN(0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .x(x), .f_w(f_w4), .f_b(f_b), .o_valid(o_valid_m), .o_ready(o_ready),
        .f_o(f_o_m), .o_class(o_class_m));

    // One frame: 4 activations (beat 0 in the LSBs), per-beat weight bits
    // (bit j = channel j), biases and expected results of all three instances.
    typedef struct {
        logic [63:0] xs;
        logic [11:0] ws;
        logic [11:0] w4;
        logic [47:0] bs;
        logic [47:0] e;
        logic [1:0]  ec;
        logic [47:0] r;
        logic [1:0]  rc;
        logic [47:0] m;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_beat(input logic [15:0] xv, input logic [2:0] wv, input logic [11:0] w4v);
        @(negedge clk);
        chk("in_ready_acc", 64'(in_ready_a), 64'd1);
        in_valid = 1'b1;
        x        = xv;
        f_w      = wv;
        f_w4     = w4v;
        @(posedge clk);
    endtask

    task automatic send_frame(input vec_t v, input int gap);
        f_b = v.bs;
        for (int i = 0; i < 4; i++) begin
            send_beat(v.xs[i*16 +: 16], v.ws[i*3 +: 3], v.w4);
            if (gap > 0 && i < 3) begin
                @(negedge clk);
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
            end
        end
    endtask

    // Called right after the posedge that accepted the last beat.
    task automatic check_result(input string tag, input vec_t v);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_bias_o_valid"}, 64'(o_valid_a), 64'd0);
        chk({tag, "_bias_in_ready"}, 64'(in_ready_a), 64'd0);
        @(negedge clk);
        chk({tag, "_o_valid"}, 64'(o_valid_a), 64'd1);
        chk({tag, "_f_o"}, 64'(f_o_a), 64'(v.e));
        chk({tag, "_o_class"}, 64'(o_class_a), 64'(v.ec));
        chk({tag, "_relu_f_o"}, 64'(f_o_r), 64'(v.r));
        chk({tag, "_relu_o_class"}, 64'(o_class_r), 64'(v.rc));
        chk({tag, "_mbit_f_o"}, 64'(f_o_m), 64'(v.m));
        if (o_ready) begin
            @(negedge clk);
            chk({tag, "_o_valid_drop"}, 64'(o_valid_a), 64'd0);
            chk({tag, "_in_ready_back"}, 64'(in_ready_a), 64'd1);
        end
    endtask

    initial begin
        // Basic: 256,512,768,1024; ch0=1111 ch1=0000 ch2=1010; bias ch2=256.
        vecs[0] = '{xs: {16'h0400, 16'h0300, 16'h0200, 16'h0100},
                    ws: {3'b001, 3'b101, 3'b001, 3'b101}, w4: 12'h000,
                    bs: {16'h0100, 16'h0000, 16'h0000},
                    e:  {16'hFF00, 16'hF600, 16'h0A00}, ec: 2'd0,
                    r:  {16'h0000, 16'h0000, 16'h0A00}, rc: 2'd0,
                    m:  {16'h0100, 16'h0000, 16'h0000}};
        // Accumulator saturation: ch0 +4*32767, ch1 -4*32767, ch2 1100 -> 0.
        vecs[1] = '{xs: {4{16'h7FFF}},
                    ws: {3'b001, 3'b001, 3'b101, 3'b101}, w4: 12'h000,
                    bs: 48'h0,
                    e:  {16'h0000, 16'h8000, 16'h7FFF}, ec: 2'd0,
                    r:  {16'h0000, 16'h0000, 16'h7FFF}, rc: 2'd0,
                    m:  48'h0};
        // All channels equal (1000) -> lowest index.
        vecs[2] = '{xs: {16'd400, 16'd300, 16'd200, 16'd100},
                    ws: 12'hFFF, w4: 12'h000,
                    bs: 48'h0,
                    e:  {16'h03E8, 16'h03E8, 16'h03E8}, ec: 2'd0,
                    r:  {16'h03E8, 16'h03E8, 16'h03E8}, rc: 2'd0,
                    m:  48'h0};
        // Winner is the last channel: -1024, -512, 512.
        vecs[3] = '{xs: {4{16'h0100}},
                    ws: {3'b000, 3'b100, 3'b100, 3'b110}, w4: 12'h000,
                    bs: 48'h0,
                    e:  {16'h0200, 16'hFE00, 16'hFC00}, ec: 2'd2,
                    r:  {16'h0200, 16'h0000, 16'h0000}, rc: 2'd2,
                    m:  48'h0};
        // Negative activations and a negative bias: -1024, 1024, -300.
        vecs[4] = '{xs: {4{16'hFF00}},
                    ws: {3'b101, 3'b001, 3'b101, 3'b001}, w4: 12'h000,
                    bs: {16'hFED4, 16'h0000, 16'h0000},
                    e:  {16'hFED4, 16'h0400, 16'hFC00}, ec: 2'd1,
                    r:  {16'h0000, 16'h0400, 16'h0000}, rc: 2'd1,
                    m:  {16'hFED4, 16'h0000, 16'h0000}};
        // Saturation caused by the bias add.
        vecs[5] = '{xs: {4{16'h0100}},
                    ws: {3'b101, 3'b101, 3'b101, 3'b101}, w4: 12'h000,
                    bs: {16'h0000, 16'h8000, 16'h7FFF},
                    e:  {16'h0400, 16'h8000, 16'h7FFF}, ec: 2'd0,
                    r:  {16'h0400, 16'h0000, 16'h7FFF}, rc: 2'd0,
                    m:  {16'h0000, 16'h8000, 16'h7FFF}};
        // Multi-bit weights: w=-2 (WFL=2), x=256 -> -128 per beat -> -512.
        vecs[6] = '{xs: {4{16'h0100}},
                    ws: 12'h000, w4: 12'hEEE,
                    bs: 48'h0,
                    e:  {16'hFC00, 16'hFC00, 16'hFC00}, ec: 2'd0,
                    r:  48'h0, rc: 2'd0,
                    m:  {16'hFE00, 16'hFE00, 16'hFE00}};

        rst      = 1'b1;
        in_valid = 1'b0;
        x        = '0;
        f_w      = '0;
        f_w4     = '0;
        f_b      = '0;
        o_ready  = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_o_valid", 64'(o_valid_a), 64'd0);
        chk("reset_in_ready", 64'(in_ready_a), 64'd1);
        chk("reset_f_o", 64'(f_o_a), 64'd0);
        chk("reset_o_class", 64'(o_class_a), 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            send_frame(vecs[k], 0);
            check_result($sformatf("vec%0d", k), vecs[k]);
        end

        // Backpressure: result held 5 cycles while junk beats are offered.
        o_ready = 1'b0;
        send_frame(vecs[0], 0);
        check_result("bp", vecs[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_hold_o_valid", 64'(o_valid_a), 64'd1);
            chk("bp_hold_in_ready", 64'(in_ready_a), 64'd0);
            chk("bp_hold_f_o", 64'(f_o_a), 64'(vecs[0].e));
            chk("bp_hold_o_class", 64'(o_class_a), 64'(vecs[0].ec));
            in_valid = 1'b1;
            x        = 16'h1234;
            f_w      = 3'b111;
        end
        @(negedge clk);
        chk("bp_last_o_valid", 64'(o_valid_a), 64'd1);
        in_valid = 1'b0;
        o_ready  = 1'b1;
        @(negedge clk);
        chk("bp_release_o_valid", 64'(o_valid_a), 64'd0);
        send_frame(vecs[0], 0);
        check_result("bp_next", vecs[0]);

        // Bubbles between beats.
        send_frame(vecs[4], 2);
        check_result("bubble", vecs[4]);

        // Reset after two beats, then a clean frame.
        send_frame(vecs[0], 0);
        check_result("pre_rst", vecs[0]);
        send_beat(16'h0100, 3'b111, 12'h111);
        send_beat(16'h0200, 3'b111, 12'h111);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        chk("midrst_o_valid", 64'(o_valid_a), 64'd0);
        chk("midrst_in_ready", 64'(in_ready_a), 64'd1);
        chk("midrst_f_o", 64'(f_o_a), 64'd0);
        chk("midrst_mbit_f_o", 64'(f_o_m), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(vecs[0], 0);
        check_result("post_rst", vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
